regfile_wr_ctrl: RTL and testbench
==================================

REGFILE_WR_CTRL -- requirements
Module: regfile_wr_ctrl

Interface
REQ-001 The block SHALL have these ports:
  - Clk  in  1  system clock; all state updates on rising edge.
  - Reset  in  1  synchronous, active-high reset.
  - A_Req  in  1  requester A (execute writeback) write request.
  - A_DR  in  3  requester A destination register.
  - A_Data  in  16  requester A write data.
  - A_Ack  out  1  requester A request accepted this cycle.
  - B_Req  in  1  requester B (load writeback) write request.
  - B_DR  in  3  requester B destination register.
  - B_Data  in  16  requester B write data.
  - B_Ack  out  1  requester B request accepted this cycle.
  - LD_REG  out  1  register-file write enable (registered).
  - DR  out  3  register-file destination select (registered).
  - Wr_Data  out  16  data driven onto the register-file write bus (registered).
  - Busy  out  1  clear sequence in progress; no acks while high.
REQ-002 There SHALL be one clock, Clk; Reset SHALL be synchronous and active-high.

Function
REQ-003 The FSM SHALL have two states, CLEAR and RUN; CLEAR exists only when REGFILE_CLEAR_EN is defined.
REQ-004 In RUN, a request SHALL be accepted in the cycle its Req is high and it wins arbitration; the winner's Ack SHALL be high combinationally in that cycle.
REQ-005 At most one Ack SHALL be high per cycle.
REQ-006 If exactly one Req is high, that requester SHALL win.
REQ-007 If both Reqs are high, the requester named by a 1-bit round-robin pointer SHALL win.
REQ-008 After every grant, the pointer SHALL point to the non-winning requester; the pointer SHALL be unchanged in cycles with no grant.
REQ-009 A requester SHALL hold Req, DR and Data stable until Ack; the controller SHALL sample DR and Data only in the Ack cycle.
REQ-010 On a grant in cycle N, LD_REG SHALL be 1 in cycle N+1, with DR and Wr_Data equal to the winner's values sampled in cycle N. Latency is exactly 1 cycle.
REQ-011 In any cycle with no grant, LD_REG SHALL be 0 in the next cycle, and DR/Wr_Data SHALL hold their previous values.
REQ-012 Sustained throughput SHALL be one write per cycle, with no bubble between back-to-back grants.
REQ-013 Both requesters targeting the same DR in the same cycle SHALL be serviced in consecutive grants in arbitration order; the last grant wins in the register file.
REQ-014 In CLEAR, the block SHALL issue 8 writes on consecutive cycles: DR=0..7 ascending, Wr_Data=16'h0000, LD_REG=1.
REQ-015 In CLEAR, A_Ack and B_Ack SHALL be 0 and Busy SHALL be 1.
REQ-016 A 3-bit clear counter SHALL step from 0 to 7 and SHALL NOT wrap. After the cycle that presents DR=7, the FSM SHALL enter RUN and Busy SHALL fall to 0 in the same edge.
REQ-017 Requests pending during CLEAR SHALL wait; they become eligible in the first RUN cycle.

Reset
REQ-018 While Reset=1, the block SHALL drive: LD_REG=0, DR=3'b000, Wr_Data=16'h0000, pointer=A, clear counter=0, A_Ack=0, B_Ack=0.
REQ-019 After Reset, the state SHALL be CLEAR with Busy=1 if REGFILE_CLEAR_EN is defined, otherwise RUN with Busy=0.
REQ-020 Reset asserted mid-clear or mid-transfer SHALL abort the operation. The next cycle's LD_REG SHALL be 0, and any clear sequence SHALL restart from DR=0.

Configuration
REQ-021 With macro REGFILE_CLEAR_EN defined, the CLEAR state and counter SHALL be built and the behaviour in REQ-014..REQ-017 applies.
REQ-022 Without REGFILE_CLEAR_EN, the CLEAR state and counter SHALL be omitted. Busy SHALL be tied to 0, and arbitration SHALL begin in the first cycle after Reset.

Verification
REQ-023 The bench SHALL cover these scenarios:
  - Clear: Reset for 1 cycle, REGFILE_CLEAR_EN defined, no Reqs. Required response: LD_REG=1 for 8 cycles with DR 0..7 and Wr_Data=0; Busy falls after DR=7; all R0..R7 read 0.
  - Single requester: A_Req=1, A_DR=3, A_Data=16'hBEEF in RUN. Required response: A_Ack in cycle N; in N+1, LD_REG=1, DR=3, Wr_Data=16'hBEEF.
  - Contention: A and B request together continuously for 4 grants, with the pointer at A after reset. Required response: grant order A,B,A,B; no two Acks in one cycle.
  - Same-DR collision: A_DR=B_DR=5, A_Data=16'h1111, B_Data=16'h2222, pointer=A. Required response: two consecutive writes to 5; R5 ends 16'h2222.
  - Reset mid-clear: assert Reset while DR=4 is presented. Required response: LD_REG=0 next cycle, then the clear restarts at DR=0; Reqs held high get no Ack until Busy=0.
  - Macro off: build without REGFILE_CLEAR_EN, A_Req=1 in the first cycle after Reset. Required response: Busy=0 throughout; A_Ack in that first cycle.

Source files
------------

// File: rtl/regfile_wr_ctrl.sv
// regfile_wr_ctrl
// ---------------
// Write-port controller for an 8 x 16 register file shared by two writers.
// Requester A (execute writeback) and requester B (load writeback) compete
// for the single write port. When both request in the same cycle, a 1-bit
// round-robin pointer picks the winner. The winner's write is presented on
// LD_REG/DR/Wr_Data exactly one cycle after its Ack.
//
// Handshake (valid/ready style): a requester raises X_Req with X_DR/X_Data
// and holds all three stable until it sees X_Ack high at a rising edge.
// X_Ack is combinational and means "DR/Data are captured at this edge".
// After that edge the requester may drop Req or present a new request.
//
// Optional feature: macro REGFILE_CLEAR_EN. When it is defined, reset enters
// a CLEAR state. That state writes 16'h0000 to R0..R7 on 8 consecutive
// cycles, and Busy is high and no Ack is given for the whole sequence. When
// the macro is undefined, the block comes out of reset directly in RUN and
// Busy is tied low.
//
// Ports
//   Clk               system clock, rising edge
//   Reset             synchronous, active-high reset
//   A_Req/A_DR/A_Data requester A request, destination, data
//   A_Ack             requester A accepted this cycle (combinational)
//   B_Req/B_DR/B_Data requester B request, destination, data
//   B_Ack             requester B accepted this cycle (combinational)
//   LD_REG            register-file write enable (registered)
//   DR                register-file destination select (registered)
//   Wr_Data           register-file write data (registered)
//   Busy              clear sequence in progress
//   dbg_state         current FSM state (0 = RUN, 1 = CLEAR)
module regfile_wr_ctrl (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        A_Req,
  input  logic [2:0]  A_DR,
  input  logic [15:0] A_Data,
  output logic        A_Ack,
  input  logic        B_Req,
  input  logic [2:0]  B_DR,
  input  logic [15:0] B_Data,
  output logic        B_Ack,
  output logic        LD_REG,
  output logic [2:0]  DR,
  output logic [15:0] Wr_Data,
  output logic        Busy,
  output logic        dbg_state
);

  localparam logic PTR_A = 1'b0;
  localparam logic PTR_B = 1'b1;

`ifdef REGFILE_CLEAR_EN
  typedef enum logic [0:0] {
    ST_RUN   = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [2:0]  clr_cnt_q, clr_cnt_d;
`else
  typedef enum logic [0:0] {
    ST_RUN = 1'b0
  } state_t;

  state_t      state_q;
  assign state_q = ST_RUN;
`endif

  logic        ptr_q, ptr_d;
  logic        ld_reg_q, ld_reg_d;
  logic [2:0]  dr_q, dr_d;
  logic [15:0] wr_data_q, wr_data_d;

  logic        run;
  logic        grant_a;
  logic        grant_b;

  // No grants while the clear runs or while Reset is held. This keeps the
  // Acks low during reset without depending on the registered state.
  assign run     = (state_q == ST_RUN) && !Reset;
  assign grant_a = run && A_Req && (!B_Req || (ptr_q == PTR_A));
  assign grant_b = run && B_Req && (!A_Req || (ptr_q == PTR_B));

  assign A_Ack     = grant_a;
  assign B_Ack     = grant_b;
  assign LD_REG    = ld_reg_q;
  assign DR        = dr_q;
  assign Wr_Data   = wr_data_q;
  assign dbg_state = state_q;

`ifdef REGFILE_CLEAR_EN
  assign Busy = (state_q == ST_CLEAR);
`else
  assign Busy = 1'b0;
`endif

  always_comb begin
    ptr_d     = ptr_q;
    ld_reg_d  = 1'b0;
    dr_d      = dr_q;
    wr_data_d = wr_data_q;
`ifdef REGFILE_CLEAR_EN
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
`endif

    if (grant_a) begin
      ld_reg_d  = 1'b1;
      dr_d      = A_DR;
      wr_data_d = A_Data;
      ptr_d     = PTR_B;
    end else if (grant_b) begin
      ld_reg_d  = 1'b1;
      dr_d      = B_DR;
      wr_data_d = B_Data;
      ptr_d     = PTR_A;
    end

`ifdef REGFILE_CLEAR_EN
    if (state_q == ST_CLEAR) begin
      // Leave CLEAR at the end of the cycle that shows the DR=7 write.
      // This makes Busy fall on the same edge that retires the last
      // clear write.
      if (ld_reg_q && (dr_q == 3'd7)) begin
        state_d = ST_RUN;
      end else begin
        ld_reg_d  = 1'b1;
        dr_d      = clr_cnt_q;
        wr_data_d = 16'h0000;
        // The counter stops at 7 and does not wrap back to 0.
        if (clr_cnt_q != 3'd7) begin
          clr_cnt_d = clr_cnt_q + 3'd1;
        end
      end
    end
`endif
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      ld_reg_q  <= 1'b0;
      dr_q      <= 3'b000;
      wr_data_q <= 16'h0000;
      ptr_q     <= PTR_A;
`ifdef REGFILE_CLEAR_EN
      state_q   <= ST_CLEAR;
      clr_cnt_q <= 3'd0;
`endif
    end else begin
      ld_reg_q  <= ld_reg_d;
      dr_q      <= dr_d;
      wr_data_q <= wr_data_d;
      ptr_q     <= ptr_d;
`ifdef REGFILE_CLEAR_EN
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
`endif
    end
  end

endmodule

// File: tb/tb_regfile_wr_ctrl.sv
// tb_regfile_wr_ctrl
// ------------------
// Self-checking bench for regfile_wr_ctrl. It runs one task per scenario,
// in sequence. A register-file sink captures the writes the DUT issues.
// The random back-to-back test compares the DUT against an arbitration
// model, where each expected write is a {DR, Data} entry in exp_q.
// Scenarios that involve the clear sequence are built when REGFILE_CLEAR_EN
// is defined. When it is undefined, the bench checks the no-clear startup.
module tb_regfile_wr_ctrl;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        A_Req = 1'b0;
  logic [2:0]  A_DR = 3'd0;
  logic [15:0] A_Data = 16'h0;
  logic        A_Ack;
  logic        B_Req = 1'b0;
  logic [2:0]  B_DR = 3'd0;
  logic [15:0] B_Data = 16'h0;
  logic        B_Ack;
  logic        LD_REG;
  logic [2:0]  DR;
  logic [15:0] Wr_Data;
  logic        Busy;
  logic        dbg_state;

  int n_vec = 0;
  int n_err = 0;

  logic [15:0] rf [8];
  logic [18:0] exp_q [$];

`ifdef REGFILE_CLEAR_EN
  localparam logic EXP_BUSY_RST = 1'b1;
`else
  localparam logic EXP_BUSY_RST = 1'b0;
`endif

  regfile_wr_ctrl dut (
    .Clk(Clk), .Reset(Reset),
    .A_Req(A_Req), .A_DR(A_DR), .A_Data(A_Data), .A_Ack(A_Ack),
    .B_Req(B_Req), .B_DR(B_DR), .B_Data(B_Data), .B_Ack(B_Ack),
    .LD_REG(LD_REG), .DR(DR), .Wr_Data(Wr_Data), .Busy(Busy),
    .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 Clk = ~Clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // The register file that the DUT writes. It is filled with a marker value
  // during reset, so any entry that reads back 0 was really written as 0.
  always @(posedge Clk) begin
    if (Reset) begin
      for (int i = 0; i < 8; i++) rf[i] <= 16'hDEAD;
    end else if (LD_REG) begin
      rf[DR] <= Wr_Data;
    end
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // Reset for one cycle, then wait until the first RUN cycle. Returns at
  // posedge+1 of that cycle.
  task automatic do_reset();
    int n;
    A_Req = 1'b0;
    B_Req = 1'b0;
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    n = 0;
    while (Busy !== 1'b0 && n < 40) begin
      tick();
      n++;
    end
    n_vec++;
    if (Busy !== 1'b0) begin
      n_err++;
      $display("FAIL reset_to_run: Busy=%b required 0 within 40 cycles", Busy);
    end
  endtask

  // driver / checks
  task automatic test_reset();
    A_Req = 1'b1; A_DR = 3'd6; A_Data = 16'h1234;
    B_Req = 1'b1; B_DR = 3'd2; B_Data = 16'h5678;
    Reset = 1'b1;
    tick();
    tick();
    @(negedge Clk);
    n_vec++; if (LD_REG !== 1'b0) begin n_err++; $display("FAIL rst_ld: got %b want 0", LD_REG); end
    n_vec++; if (DR !== 3'd0) begin n_err++; $display("FAIL rst_dr: got %0d want 0", DR); end
    n_vec++; if (Wr_Data !== 16'h0) begin n_err++; $display("FAIL rst_wdata: got %h want 0000", Wr_Data); end
    n_vec++; if (A_Ack !== 1'b0 || B_Ack !== 1'b0) begin n_err++; $display("FAIL rst_ack: got %b%b want 00", A_Ack, B_Ack); end
    n_vec++; if (Busy !== EXP_BUSY_RST) begin n_err++; $display("FAIL rst_busy: got %b want %b", Busy, EXP_BUSY_RST); end
    A_Req = 1'b0;
    B_Req = 1'b0;
  endtask

`ifdef REGFILE_CLEAR_EN
  task automatic test_clear();
    A_Req = 1'b0;
    B_Req = 1'b0;
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    @(negedge Clk);
    n_vec++; if (Busy !== 1'b1 || LD_REG !== 1'b0) begin n_err++; $display("FAIL clr_start: Busy=%b LD=%b want 1 0", Busy, LD_REG); end
    for (int k = 0; k < 8; k++) begin
      tick();
      @(negedge Clk);
      n_vec++;
      if (LD_REG !== 1'b1 || DR !== k[2:0] || Wr_Data !== 16'h0 || Busy !== 1'b1) begin
        n_err++;
        $display("FAIL clr_write%0d: LD=%b DR=%0d WD=%h Busy=%b want 1 %0d 0000 1", k, LD_REG, DR, Wr_Data, Busy, k);
      end
    end
    tick();
    @(negedge Clk);
    n_vec++; if (Busy !== 1'b0 || LD_REG !== 1'b0) begin n_err++; $display("FAIL clr_end: Busy=%b LD=%b want 0 0", Busy, LD_REG); end
    for (int i = 0; i < 8; i++) begin
      n_vec++;
      if (rf[i] !== 16'h0) begin n_err++; $display("FAIL clr_rf%0d: got %h want 0000", i, rf[i]); end
    end
  endtask

  task automatic test_reset_mid_clear();
    logic        found;
    logic [15:0] a_d, b_d;
    a_d = 16'($urandom);
    b_d = 16'($urandom);
    A_Req = 1'b1; A_DR = 3'd2; A_Data = a_d;
    B_Req = 1'b1; B_DR = 3'd6; B_Data = b_d;
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    found = 1'b0;
    for (int n = 0; n < 20; n++) begin
      @(negedge Clk);
      n_vec++;
      if (A_Ack !== 1'b0 || B_Ack !== 1'b0) begin n_err++; $display("FAIL midclr_ack_busy: got %b%b want 00", A_Ack, B_Ack); end
      if (LD_REG === 1'b1 && DR === 3'd4) begin
        found = 1'b1;
        Reset = 1'b1;
        break;
      end
      tick();
    end
    n_vec++;
    if (!found) begin n_err++; $display("FAIL midclr_find: DR=4 write not seen, found=%b want 1", found); end
    tick();
    Reset = 1'b0;
    @(negedge Clk);
    n_vec++; if (LD_REG !== 1'b0 || Busy !== 1'b1) begin n_err++; $display("FAIL midclr_abort: LD=%b Busy=%b want 0 1", LD_REG, Busy); end
    for (int k = 0; k < 8; k++) begin
      tick();
      @(negedge Clk);
      n_vec++;
      if (LD_REG !== 1'b1 || DR !== k[2:0] || A_Ack !== 1'b0 || B_Ack !== 1'b0) begin
        n_err++;
        $display("FAIL midclr_restart%0d: LD=%b DR=%0d ack=%b%b want 1 %0d 00", k, LD_REG, DR, A_Ack, B_Ack, k);
      end
    end
    tick();
    @(negedge Clk);
    n_vec++; if (Busy !== 1'b0 || A_Ack !== 1'b1 || B_Ack !== 1'b0) begin n_err++; $display("FAIL midclr_first_run: Busy=%b ack=%b%b want 0 10", Busy, A_Ack, B_Ack); end
    tick();
    A_Req = 1'b0;
    @(negedge Clk);
    n_vec++; if (B_Ack !== 1'b1 || LD_REG !== 1'b1 || DR !== 3'd2 || Wr_Data !== a_d) begin
      n_err++; $display("FAIL midclr_a_write: B_Ack=%b LD=%b DR=%0d WD=%h want 1 1 2 %h", B_Ack, LD_REG, DR, Wr_Data, a_d);
    end
    tick();
    B_Req = 1'b0;
    @(negedge Clk);
    n_vec++; if (LD_REG !== 1'b1 || DR !== 3'd6 || Wr_Data !== b_d) begin
      n_err++; $display("FAIL midclr_b_write: LD=%b DR=%0d WD=%h want 1 6 %h", LD_REG, DR, Wr_Data, b_d);
    end
  endtask
`else
  task automatic test_macro_off();
    logic [15:0] a_d;
    a_d = 16'($urandom);
    A_Req = 1'b1; A_DR = 3'd4; A_Data = a_d;
    B_Req = 1'b0;
    Reset = 1'b1;
    tick();
    @(negedge Clk);
    n_vec++; if (A_Ack !== 1'b0 || Busy !== 1'b0) begin n_err++; $display("FAIL off_in_reset: A_Ack=%b Busy=%b want 0 0", A_Ack, Busy); end
    tick();
    Reset = 1'b0;
    @(negedge Clk);
    n_vec++; if (A_Ack !== 1'b1 || Busy !== 1'b0) begin n_err++; $display("FAIL off_first_cycle: A_Ack=%b Busy=%b want 1 0", A_Ack, Busy); end
    tick();
    A_Req = 1'b0;
    @(negedge Clk);
    n_vec++; if (LD_REG !== 1'b1 || DR !== 3'd4 || Wr_Data !== a_d || Busy !== 1'b0) begin
      n_err++; $display("FAIL off_write: LD=%b DR=%0d WD=%h Busy=%b want 1 4 %h 0", LD_REG, DR, Wr_Data, Busy, a_d);
    end
  endtask
`endif

  task automatic test_single();
    do_reset();
    A_Req = 1'b1; A_DR = 3'd3; A_Data = 16'hBEEF;
    B_Req = 1'b0;
    @(negedge Clk);
    n_vec++; if (A_Ack !== 1'b1 || B_Ack !== 1'b0) begin n_err++; $display("FAIL single_ack: got %b%b want 10", A_Ack, B_Ack); end
    tick();
    A_Req = 1'b0;
    @(negedge Clk);
    n_vec++; if (LD_REG !== 1'b1 || DR !== 3'd3 || Wr_Data !== 16'hBEEF || A_Ack !== 1'b0) begin
      n_err++; $display("FAIL single_write: LD=%b DR=%0d WD=%h ack=%b want 1 3 beef 0", LD_REG, DR, Wr_Data, A_Ack);
    end
    tick();
    @(negedge Clk);
    n_vec++; if (LD_REG !== 1'b0 || DR !== 3'd3 || Wr_Data !== 16'hBEEF) begin
      n_err++; $display("FAIL single_hold: LD=%b DR=%0d WD=%h want 0 3 beef", LD_REG, DR, Wr_Data);
    end
  endtask

  task automatic test_contention();
    logic        m_ptr;
    logic        win;
    logic [18:0] prev;
    m_ptr = 1'b0;
    prev = '0;
    do_reset();
    A_Req = 1'b1; A_DR = 3'd1; A_Data = 16'($urandom);
    B_Req = 1'b1; B_DR = 3'd2; B_Data = 16'($urandom);
    for (int g = 0; g < 4; g++) begin
      @(negedge Clk);
      win = m_ptr;
      n_vec++;
      if (A_Ack !== !win || B_Ack !== win) begin
        n_err++; $display("FAIL contention_grant%0d: ack=%b%b want %b%b", g, A_Ack, B_Ack, !win, win);
      end
      if (g > 0) begin
        n_vec++;
        if (LD_REG !== 1'b1 || {DR, Wr_Data} !== prev) begin
          n_err++; $display("FAIL contention_write%0d: LD=%b DR/WD=%h want 1 %h", g, LD_REG, {DR, Wr_Data}, prev);
        end
      end
      prev = win ? {B_DR, B_Data} : {A_DR, A_Data};
      m_ptr = !win;
      tick();
      if (win) B_Data = 16'($urandom);
      else     A_Data = 16'($urandom);
    end
    @(negedge Clk);
    n_vec++;
    if (LD_REG !== 1'b1 || {DR, Wr_Data} !== prev) begin
      n_err++; $display("FAIL contention_write4: LD=%b DR/WD=%h want 1 %h", LD_REG, {DR, Wr_Data}, prev);
    end
    tick();
    A_Req = 1'b0;
    B_Req = 1'b0;
  endtask

  task automatic test_same_dr();
    do_reset();
    A_Req = 1'b1; A_DR = 3'd5; A_Data = 16'h1111;
    B_Req = 1'b1; B_DR = 3'd5; B_Data = 16'h2222;
    @(negedge Clk);
    n_vec++; if (A_Ack !== 1'b1 || B_Ack !== 1'b0) begin n_err++; $display("FAIL samedr_first: ack=%b%b want 10", A_Ack, B_Ack); end
    tick();
    A_Req = 1'b0;
    @(negedge Clk);
    n_vec++; if (B_Ack !== 1'b1 || LD_REG !== 1'b1 || DR !== 3'd5 || Wr_Data !== 16'h1111) begin
      n_err++; $display("FAIL samedr_w1: B_Ack=%b LD=%b DR=%0d WD=%h want 1 1 5 1111", B_Ack, LD_REG, DR, Wr_Data);
    end
    tick();
    B_Req = 1'b0;
    @(negedge Clk);
    n_vec++; if (LD_REG !== 1'b1 || DR !== 3'd5 || Wr_Data !== 16'h2222) begin
      n_err++; $display("FAIL samedr_w2: LD=%b DR=%0d WD=%h want 1 5 2222", LD_REG, DR, Wr_Data);
    end
    tick();
    n_vec++; if (rf[5] !== 16'h2222) begin n_err++; $display("FAIL samedr_rf5: got %h want 2222", rf[5]); end
  endtask

  // Random traffic. Each requester raises a request at random and holds it
  // until it is granted. The model applies the arbitration rules: a lone
  // request wins, a tie goes to the pointer, and the pointer then moves to
  // the loser. Every expected write is queued and must appear one cycle later.
  task automatic test_back_to_back();
    logic        m_ptr, a_pend, b_pend, ea, eb;
    logic [18:0] w, last_w;
    m_ptr = 1'b0;
    a_pend = 1'b0;
    b_pend = 1'b0;
    exp_q.delete();
`ifdef REGFILE_CLEAR_EN
    last_w = {3'd7, 16'h0000};
`else
    last_w = {3'd0, 16'h0000};
`endif
    do_reset();
    for (int cyc = 0; cyc < 300; cyc++) begin
      if (!a_pend && $urandom_range(0, 3) != 0) begin
        a_pend = 1'b1; A_DR = 3'($urandom_range(0, 7)); A_Data = 16'($urandom);
      end
      if (!b_pend && $urandom_range(0, 3) != 0) begin
        b_pend = 1'b1; B_DR = 3'($urandom_range(0, 7)); B_Data = 16'($urandom);
      end
      A_Req = a_pend;
      B_Req = b_pend;
      @(negedge Clk);
      ea = a_pend && (!b_pend || m_ptr == 1'b0);
      eb = b_pend && (!a_pend || m_ptr == 1'b1);
      n_vec++;
      if (A_Ack !== ea || B_Ack !== eb || Busy !== 1'b0) begin
        n_err++; $display("FAIL b2b_ack c%0d: ack=%b%b busy=%b want %b%b 0", cyc, A_Ack, B_Ack, Busy, ea, eb);
      end
      n_vec++;
      if (exp_q.size() > 0) begin
        w = exp_q.pop_front();
        last_w = w;
        if (LD_REG !== 1'b1 || {DR, Wr_Data} !== w) begin
          n_err++; $display("FAIL b2b_write c%0d: LD=%b DR/WD=%h want 1 %h", cyc, LD_REG, {DR, Wr_Data}, w);
        end
      end else if (LD_REG !== 1'b0 || {DR, Wr_Data} !== last_w) begin
        n_err++; $display("FAIL b2b_idle c%0d: LD=%b DR/WD=%h want 0 %h", cyc, LD_REG, {DR, Wr_Data}, last_w);
      end
      if (ea) begin
        exp_q.push_back({A_DR, A_Data}); m_ptr = 1'b1; a_pend = 1'b0;
      end else if (eb) begin
        exp_q.push_back({B_DR, B_Data}); m_ptr = 1'b0; b_pend = 1'b0;
      end
      tick();
    end
    A_Req = 1'b0;
    B_Req = 1'b0;
  endtask

  initial begin
    test_reset();
`ifdef REGFILE_CLEAR_EN
    test_clear();
    test_reset_mid_clear();
`else
    test_macro_off();
`endif
    test_single();
    test_contention();
    test_same_dr();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
